// File: rtl/modexp_io_buffer_pkg.sv
// Shared constants and state encoding for the ModExp operand/result staging buffer.
package modexp_io_buffer_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int NUM_WORDS  = 64;
  localparam int ADDR_W     = 6;

  // Address of the final word of an operand or result.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    LOAD         = 3'd1,
    READY        = 3'd2,
    RESULT_READY = 3'd3,
    UNLOAD       = 3'd4
  } state_t;

  // Next word address; wraps naturally at NUM_WORDS, which the FSM relies on
  // only for the read-ahead address on the final unload word.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
    return addr + 1'b1;
  endfunction

  // True when a word-serial load or unload has reached its final word.
  function automatic logic is_last(input logic [ADDR_W-1:0] addr);
    return addr == LAST_ADDR;
  endfunction

endpackage

// File: rtl/modexp_io_buffer_io_word_ram.sv
// Single-write, single-registered-read word store used for every operand and
// for the result. Contents are never cleared; only the read register resets so
// the buffer's data outputs come up as zero.
module io_word_ram
  import modexp_io_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  // Storage write port; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its last value while re is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/modexp_io_buffer.sv
// ModExp-side staging buffer: receives five word-serial operands plus nprime0,
// serves the engine random-access operand reads, captures the engine result
// and streams it back to the host word 0 first.
module modexp_io_buffer
  import modexp_io_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_input,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] m_buf,
  input  logic [DATA_WIDTH-1:0] e_buf,
  input  logic [DATA_WIDTH-1:0] n_buf,
  input  logic [DATA_WIDTH-1:0] r_buf,
  input  logic [DATA_WIDTH-1:0] t_buf,
  input  logic [63:0]           nprime0,
  input  logic                  get_result,
  input  logic [ADDR_W-1:0]     eng_rd_addr,
  output logic [DATA_WIDTH-1:0] eng_m,
  output logic [DATA_WIDTH-1:0] eng_e,
  output logic [DATA_WIDTH-1:0] eng_n,
  output logic [DATA_WIDTH-1:0] eng_r,
  output logic [DATA_WIDTH-1:0] eng_t,
  output logic [63:0]           eng_nprime0,
  output logic                  operands_ready,
  input  logic                  res_we,
  input  logic [ADDR_W-1:0]     res_waddr,
  input  logic [DATA_WIDTH-1:0] res_wdata,
  input  logic                  eng_done,
  output logic                  result_ready,
  output logic [DATA_WIDTH-1:0] res_out,
  output logic                  res_valid,
  output logic                  res_last,
  output logic                  busy
);

  state_t                state;
  logic [ADDR_W-1:0]     word_cnt;
  logic [ADDR_W-1:0]     cnt_inc;
  logic                  op_we;
  logic                  res_wr;
  logic                  eng_re;
  logic [ADDR_W-1:0]     res_raddr;
  logic [DATA_WIDTH-1:0] res_q;

  assign cnt_inc = next_addr(word_cnt);

  // Operand words land only while loading; result words only while the
  // engine owns the buffer.
  assign op_we  = (state == LOAD) && in_valid;
  assign res_wr = (state == READY) && res_we;

  // Engine reads are served once operands are complete.
  assign eng_re = (state == READY) || (state == RESULT_READY);

  // The result RAM reads one word ahead of the unload counter: outside
  // UNLOAD it keeps fetching word 0, so word 0 is already in the read
  // register on the first unload cycle and the stream never stalls.
  assign res_raddr = (state == UNLOAD) ? cnt_inc : '0;

  assign res_out = res_valid ? res_q : '0;
  assign busy    = (state == LOAD) || (state == UNLOAD);

  io_word_ram u_ram_m (
    .clk(clk), .reset(reset), .we(op_we), .waddr(word_cnt), .wdata(m_buf),
    .re(eng_re), .raddr(eng_rd_addr), .rdata(eng_m)
  );

  io_word_ram u_ram_e (
    .clk(clk), .reset(reset), .we(op_we), .waddr(word_cnt), .wdata(e_buf),
    .re(eng_re), .raddr(eng_rd_addr), .rdata(eng_e)
  );

  io_word_ram u_ram_n (
    .clk(clk), .reset(reset), .we(op_we), .waddr(word_cnt), .wdata(n_buf),
    .re(eng_re), .raddr(eng_rd_addr), .rdata(eng_n)
  );

  io_word_ram u_ram_r (
    .clk(clk), .reset(reset), .we(op_we), .waddr(word_cnt), .wdata(r_buf),
    .re(eng_re), .raddr(eng_rd_addr), .rdata(eng_r)
  );

  io_word_ram u_ram_t (
    .clk(clk), .reset(reset), .we(op_we), .waddr(word_cnt), .wdata(t_buf),
    .re(eng_re), .raddr(eng_rd_addr), .rdata(eng_t)
  );

  io_word_ram u_ram_res (
    .clk(clk), .reset(reset), .we(res_wr), .waddr(res_waddr), .wdata(res_wdata),
    .re(1'b1), .raddr(res_raddr), .rdata(res_q)
  );

  // Buffer FSM: load sequencing, engine handoff and result unload, with all
  // status flags registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      word_cnt       <= '0;
      eng_nprime0    <= '0;
      operands_ready <= 1'b0;
      result_ready   <= 1'b0;
      res_valid      <= 1'b0;
      res_last       <= 1'b0;
    end else begin
      case (state)
        IDLE, READY, RESULT_READY: begin
          if (start_input) begin
            // A new load takes priority over engine/host handshakes and
            // discards any in_valid word presented in the same cycle.
            eng_nprime0    <= nprime0;
            word_cnt       <= '0;
            state          <= LOAD;
            operands_ready <= 1'b0;
            result_ready   <= 1'b0;
          end else if ((state == READY) && eng_done) begin
            state        <= RESULT_READY;
            result_ready <= 1'b1;
          end else if ((state == RESULT_READY) && get_result) begin
            word_cnt     <= '0;
            state        <= UNLOAD;
            result_ready <= 1'b0;
            res_valid    <= 1'b1;
            res_last     <= 1'b0;
          end
        end

        LOAD: begin
          if (in_valid) begin
            if (is_last(word_cnt)) begin
              word_cnt       <= '0;
              state          <= READY;
              operands_ready <= 1'b1;
            end else begin
              word_cnt <= cnt_inc;
            end
          end
        end

        UNLOAD: begin
          if (is_last(word_cnt)) begin
            // Operands stay valid so the engine can be rerun without a reload.
            word_cnt  <= '0;
            state     <= READY;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
          end else begin
            word_cnt <= cnt_inc;
            res_last <= is_last(cnt_inc);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/modexp_io_buffer.md
Name: modexp_io_buffer

Overview:
Operand/result staging buffer on the ModExp side of the 64-bit word-serial host interface. It receives the five 4096-bit operands (m, e, n, r, t) as 64 words each, least-significant word first, plus nprime0, and holds them for the exponentiation engine's random-access reads. It captures the engine's result words and streams them back to the host word-serially. It is the receive/transmit counterpart of the host-side serializer that drives m_buf/e_buf/n_buf/r_buf/t_buf and reads res_out.

Parameters:
DATA_WIDTH, 64, word width in bits
NUM_WORDS, 64, words per operand (4096/64)
ADDR_W, 6, word-address width, log2(NUM_WORDS)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start_input  in  1  pulse; begin a new operand load
in_valid  in  1  current m/e/n/r/t_buf words valid this cycle
m_buf  in  DATA_WIDTH  message word
e_buf  in  DATA_WIDTH  exponent word
n_buf  in  DATA_WIDTH  modulus word
r_buf  in  DATA_WIDTH  R mod n word
t_buf  in  DATA_WIDTH  R^2 mod n word
nprime0  in  64  -n^-1 mod 2^64; sampled on start_input
get_result  in  1  pulse; request result stream
eng_rd_addr  in  ADDR_W  engine operand word address
eng_m, eng_e, eng_n, eng_r, eng_t  out  DATA_WIDTH each  operand words at eng_rd_addr, 1-cycle latency
eng_nprime0  out  64  latched nprime0
operands_ready  out  1  level; all operands loaded, engine may run
res_we  in  1  engine result-word write strobe
res_waddr  in  ADDR_W  result word address
res_wdata  in  DATA_WIDTH  result word
eng_done  in  1  pulse; engine result complete
result_ready  out  1  level; result captured, awaiting get_result
res_out  out  DATA_WIDTH  result word to host
res_valid  out  1  res_out valid this cycle
res_last  out  1  with res_valid on word NUM_WORDS-1
busy  out  1  state is LOAD or UNLOAD

Behaviour:
- Reset (reset=0, async): state IDLE; word counter 0; all outputs 0 (eng_* data, eng_nprime0, res_out, flags). Operand/result storage contents not cleared and undefined after reset.
- States: IDLE, LOAD, READY, RESULT_READY, UNLOAD.
- IDLE/READY/RESULT_READY + start_input: latch nprime0, counter<=0, ->LOAD, operands_ready<=0, result_ready<=0. start_input ignored in LOAD and UNLOAD.
- LOAD: each in_valid cycle writes all five words at address counter, counter+1. Write with counter==NUM_WORDS-1: counter<=0, ->READY, operands_ready<=1 next cycle. in_valid low = stall, no write. start_input and in_valid in the same cycle from IDLE: start only, word not written.
- in_valid outside LOAD: ignored.
- READY: eng_* = storage[eng_rd_addr] registered (issued cycle k, valid k+1); reads also valid in RESULT_READY. res_we writes result[res_waddr]; res_we ignored in all other states. eng_done -> RESULT_READY, result_ready<=1; operands_ready stays 1. res_we and eng_done same cycle: word written, then transition.
- RESULT_READY + get_result: counter<=0, ->UNLOAD, result_ready<=0. get_result in other states ignored.
- UNLOAD: NUM_WORDS consecutive cycles res_valid=1, res_out=result[counter], word 0 first, no stalls; res_last=1 on final word; then ->READY (operands retained, engine may be rerun by host via new eng_done cycle), res_valid<=0, res_out<=0.
- Counter wraps only via explicit transitions; never exceeds NUM_WORDS-1.

Decomposition:
- Shared package: DATA_WIDTH, NUM_WORDS, ADDR_W, state encoding constants (IDLE=0 .. UNLOAD=4).
- Sub-module io_word_ram (1 write port, 1 registered read port, DATA_WIDTH x NUM_WORDS), instantiated six times (m,e,n,r,t,result).

Test Plan:
- Reset mid-LOAD after 10 words -> state IDLE, operands_ready=0, busy=0, all outputs 0 while reset low.
- Load m=8, e=13, n=77, r/t arbitrary, nprime0=64'h1234 -> operands_ready=1 one cycle after 64th in_valid; eng_rd_addr=0 -> eng_m=8, eng_e=13, eng_n=77 next cycle; addr 1..63 -> 0; eng_nprime0=64'h1234.
- Load with in_valid low every other cycle -> identical storage contents, LOAD lasts 128 cycles.
- Engine writes word0=50, words 1..63=0, eng_done; get_result -> 64 res_valid cycles, res_out=50 first then 0, res_last only on cycle 64, then READY.
- in_valid/res_we in IDLE and get_result in READY -> no storage change, no state change, res_valid stays 0.
- start_input during UNLOAD -> ignored, stream completes all 64 words.
